// File: rtl/traffic_source_pkg.sv
// Shared definitions for the packet traffic injector: FSM states, flit bit
// offsets and the LFSR polynomial, also used by the matching sinks.
package traffic_source_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Head and tail flags sit at these offsets below the flit width.
  localparam int HEAD_OFS = 1;
  localparam int TAIL_OFS = 2;

  // Galois form of x^32 + x^22 + x^2 + x + 1.
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_MASK) : (v >> 1);
  endfunction

  // An all-zero Galois LFSR never leaves zero, so zero is replaced by 1.
  function automatic logic [31:0] eff_seed(input logic [31:0] id, input logic [31:0] seed);
    logic [31:0] s;
    s = seed ^ id;
    return (s == 32'd0) ? 32'd1 : s;
  endfunction

endpackage

// File: rtl/traffic_source_if.sv
// Two-phase (toggle) req/ack flit channel between a traffic source and a sink.
interface traffic_source_if #(
  parameter int SIZE = 16
) ();
  logic            req;
  logic            ack;
  logic [SIZE-1:0] data;

  modport master (output req, output data, input ack);
  modport slave  (input req, input data, output ack);
endinterface

// File: rtl/traffic_source_lfsr32.sv
// 32-bit Galois LFSR that steps once per advance pulse; low OUT_W bits exposed.
module lfsr32
  import traffic_source_pkg::*;
#(
  parameter logic [31:0] SEED  = 32'd1,
  parameter int          OUT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             advance,
  output logic [OUT_W-1:0] value
);

  localparam logic [31:0] INIT = (SEED == 32'd0) ? 32'd1 : SEED;

  logic [31:0] state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= INIT;
    end else if (advance) begin
      state_q <= lfsr_step(state_q);
    end
  end

  assign value = state_q[OUT_W-1:0];

endmodule

// File: rtl/traffic_source.sv
// Multi-flit packet injector on a 2-phase req/ack channel with LFSR payload,
// round-robin destinations, inter-packet gap and enable-gated packet starts.
module traffic_source
  import traffic_source_pkg::*;
#(
  parameter int          ID         = 0,
  parameter int          SIZE       = 16,
  parameter int          FLITS      = 4,
  parameter int          PACKETS    = 2,
  parameter int          DEST_BITS  = 4,
  parameter int          DEST_COUNT = 16,
  parameter int          GAP        = 0,
  parameter logic [31:0] SEED       = 32'd1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  traffic_source_if.master ch,
  output logic             done,
  output logic [7:0]       pkt_count
);

  localparam int                   PAY_W     = SIZE - 2;
  localparam logic [31:0]          EFF_SEED  = eff_seed(32'(ID), SEED);
  localparam logic [7:0]           FLITS_L   = 8'(FLITS);
  localparam logic [7:0]           PKT_LAST  = 8'(PACKETS - 1);
  localparam logic [7:0]           GAP_L     = 8'(GAP);
  localparam logic [DEST_BITS-1:0] DEST_LAST = DEST_BITS'(DEST_COUNT - 1);

  state_t               state;
  logic                 ack_old;
  logic                 req_r;
  logic [SIZE-1:0]      data_r;
  logic [7:0]           flit_idx;
  logic [7:0]           gap_cnt;
  logic [DEST_BITS-1:0] dest_cnt;
  logic [PAY_W-1:0]     lfsr_val;
  logic                 ack_rx;
  logic                 issue_head;
  logic                 issue_next;

  assign ack_rx     = ch.ack ^ ack_old;
  assign issue_head = (state == ST_IDLE) && !done && enable;
  assign issue_next = (state == ST_WAIT) && ack_rx && (flit_idx < FLITS_L);

  // The issued flit carries the pre-advance LFSR value.
  lfsr32 #(
    .SEED  (EFF_SEED),
    .OUT_W (PAY_W)
  ) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .advance (issue_head | issue_next),
    .value   (lfsr_val)
  );

  function automatic logic [SIZE-1:0] make_flit(input logic [7:0]           idx,
                                                input logic [DEST_BITS-1:0] dest,
                                                input logic [PAY_W-1:0]     pay);
    logic [SIZE-1:0] f;
    f = {2'b00, pay};
    f[SIZE-HEAD_OFS] = (idx == 8'd0);
    f[SIZE-TAIL_OFS] = (idx == FLITS_L - 8'd1);
    if (idx == 8'd0) f[SIZE-3 -: DEST_BITS] = dest;
    return f;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      ack_old   <= 1'b0;
      req_r     <= 1'b0;
      data_r    <= '0;
      flit_idx  <= 8'd0;
      gap_cnt   <= 8'd0;
      dest_cnt  <= '0;
      done      <= 1'b0;
      pkt_count <= 8'd0;
    end else begin
      // Toggles outside WAIT are absorbed here and never acted on.
      ack_old <= ch.ack;
      case (state)
        ST_IDLE: begin
          if (issue_head) begin
            data_r   <= make_flit(8'd0, dest_cnt, lfsr_val);
            req_r    <= ~req_r;
            flit_idx <= 8'd1;
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (issue_next) begin
            data_r   <= make_flit(flit_idx, dest_cnt, lfsr_val);
            req_r    <= ~req_r;
            flit_idx <= flit_idx + 8'd1;
          end else if (ack_rx) begin
            pkt_count <= pkt_count + 8'd1;
            flit_idx  <= 8'd0;
            // Follow pkt_count mod DEST_COUNT, including the 255->0 wrap.
            dest_cnt  <= (dest_cnt == DEST_LAST || pkt_count == 8'hFF) ? '0 : dest_cnt + 1'b1;
            if (PACKETS != 0 && pkt_count == PKT_LAST) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else if (GAP != 0) begin
              state   <= ST_GAP;
              gap_cnt <= GAP_L;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_GAP: begin
          gap_cnt <= gap_cnt - 8'd1;
          if (gap_cnt == 8'd1) state <= ST_IDLE;
        end
        ST_DONE: begin
          done <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign ch.req  = req_r;
  assign ch.data = data_r;

endmodule

// File: tb/tb_traffic_source.sv
// Directed bench for traffic_source: two instances (default packet shape, and
// single-flit packets with a gap) checked against a flit-sequence model.
module tb_traffic_source;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  enable;
  logic        ack_v [2];
  logic        req_v [2];
  logic [15:0] data_v [2];
  logic [1:0]  done_v;
  logic [7:0]  pc_v [2];

  int total, bad, cyc;
  int k [2];
  int lat [2][16];
  int last_ack_cyc [2];
  int cnt [2];
  logic last_req [2];
  logic prev_req [2];
  logic [15:0] prev_data [2];
  logic [15:0] cur_log [2][8];
  logic [15:0] snap [2][8];
  bit resp_en;

  // Instance parameters as the model sees them: seed already has ID folded in.
  int seed_c  [2] = '{1, 2};
  int flits_c [2] = '{4, 1};
  int pkts_c  [2] = '{2, 3};

  always #5 clk = ~clk;

  traffic_source_if #(.SIZE(16)) if_a ();
  traffic_source_if #(.SIZE(16)) if_b ();

  assign if_a.ack  = ack_v[0];
  assign if_b.ack  = ack_v[1];
  assign req_v[0]  = if_a.req;
  assign req_v[1]  = if_b.req;
  assign data_v[0] = if_a.data;
  assign data_v[1] = if_b.data;

  traffic_source dut_a (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable[0]),
    .ch        (if_a),
    .done      (done_v[0]),
    .pkt_count (pc_v[0])
  );

  traffic_source #(
    .ID      (3),
    .FLITS   (1),
    .PACKETS (3),
    .GAP     (5)
  ) dut_b (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable[1]),
    .ch        (if_b),
    .done      (done_v[1]),
    .pkt_count (pc_v[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Flit number kk of an instance, straight from the packet format rules.
  function automatic logic [15:0] exp_flit(input int i, input int kk);
    logic [31:0] v;
    logic [15:0] r;
    int p, f;
    p = kk / flits_c[i];
    f = kk % flits_c[i];
    v = seed_c[i];
    for (int n = 0; n < kk; n++) v = v[0] ? ((v >> 1) ^ 32'h80200003) : (v >> 1);
    r = {(f == 0), (f == flits_c[i] - 1), v[13:0]};
    if (f == 0) r[13:10] = 4'(p % 16);
    return r;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Responder: toggles ack two cycles after it sees each req toggle.
  initial forever begin
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (!resp_en || reset) begin
        cnt[i]      = 0;
        last_req[i] = req_v[i];
      end else if (req_v[i] !== last_req[i]) begin
        last_req[i] = req_v[i];
        cnt[i]      = 2;
      end else if (cnt[i] > 0) begin
        cnt[i]--;
        if (cnt[i] == 0) begin
          ack_v[i]        = ~ack_v[i];
          last_ack_cyc[i] = cyc;
        end
      end
    end
  end

  // Compare process: every req toggle must present the next modelled flit,
  // data must hold between toggles, and done only after the last flit.
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        k[i]         = 0;
        prev_req[i]  = 1'b0;
        prev_data[i] = '0;
      end else begin
        if (req_v[i] !== prev_req[i]) begin
          chk("flit_within_budget", k[i] < pkts_c[i] * flits_c[i], 1);
          chk("flit_data", data_v[i], exp_flit(i, k[i]));
          if (k[i] < 16) lat[i][k[i]] = cyc - last_ack_cyc[i];
          if (k[i] < 8) cur_log[i][k[i]] = data_v[i];
          k[i]++;
        end else begin
          chk("data_hold", data_v[i], prev_data[i]);
        end
        chk("done_after_last_flit", !done_v[i] || (k[i] == pkts_c[i] * flits_c[i]), 1);
        prev_req[i]  = req_v[i];
        prev_data[i] = data_v[i];
      end
    end
  end

  task automatic wait_pc(input int i, input int v, input int budget, input string name);
    int n;
    n = 0;
    while (pc_v[i] != 8'(v) && n < budget) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk(name, pc_v[i], v);
  endtask

  task automatic wait_done(input int i, input int budget, input string name);
    int n;
    n = 0;
    while (done_v[i] !== 1'b1 && n < budget) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk(name, done_v[i], 1);
  endtask

  task automatic wait_k(input int i, input int v, input int budget, input string name);
    int n;
    n = 0;
    while (k[i] != v && n < budget) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk(name, k[i], v);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "time limit");
  end

  initial begin
    reset    = 1'b1;
    enable   = 2'b00;
    ack_v[0] = 1'b0;
    ack_v[1] = 1'b0;
    resp_en  = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    @(negedge clk);
    #2;
    for (int i = 0; i < 2; i++) begin
      chk("reset_req", req_v[i], 0);
      chk("reset_data", data_v[i], 0);
      chk("reset_done", done_v[i], 0);
      chk("reset_pkt_count", pc_v[i], 0);
    end

    // Idle with enable low, including a stray ack toggle.
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2;
    ack_v[0] = ~ack_v[0];
    ack_v[1] = ~ack_v[1];
    repeat (5) @(negedge clk);
    for (int i = 0; i < 2; i++) chk("idle_no_req", req_v[i], 0);

    resp_en = 1'b1;
    @(posedge clk);
    #1 enable = 2'b11;
    @(negedge clk);
    for (int i = 0; i < 2; i++) chk("req_before_edge", req_v[i], 0);
    @(negedge clk);
    for (int i = 0; i < 2; i++) chk("req_1clk_after_enable", req_v[i], 1);
    enable[0] = 1'b0;

    // Stray toggle while B sits in its gap.
    wait_pc(1, 1, 100, "b_first_packet");
    @(posedge clk);
    #2 ack_v[1] = ~ack_v[1];

    // A finishes packet 0 with enable low and must then stay idle.
    wait_pc(0, 1, 200, "a_first_packet");
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 ack_v[0] = ~ack_v[0];
    repeat (8) @(negedge clk);
    #2;
    chk("a_no_head_while_disabled", k[0], 4);
    chk("a_pkt_count_hold", pc_v[0], 1);
    chk("a_not_done", done_v[0], 0);

    @(posedge clk);
    #1 enable[0] = 1'b1;
    wait_done(0, 300, "a_done");
    wait_done(1, 300, "b_done");
    chk("a_pkt_count_final", pc_v[0], 2);
    chk("b_pkt_count_final", pc_v[1], 3);
    chk("a_flit_total", k[0], 8);
    chk("b_flit_total", k[1], 3);

    // Hand-derived flits pin the model.
    chk("a_flit0_literal", cur_log[0][0], 16'h8001);
    chk("a_flit1_literal", cur_log[0][1], 16'h0003);
    chk("a_flit2_literal", cur_log[0][2], 16'h0002);
    chk("a_flit3_literal", cur_log[0][3], 16'h4001);
    chk("a_flit4_literal", cur_log[0][4], 16'h8403);
    chk("b_flit0_literal", cur_log[1][0], 16'hC002);
    chk("b_flit1_literal", cur_log[1][1], 16'hC401);
    chk("b_flit2_literal", cur_log[1][2], 16'hC803);
    for (int j = 1; j < 4; j++) chk("a_body_spacing", lat[0][j], 1);
    chk("b_gap_spacing_1", lat[1][1], 7);
    chk("b_gap_spacing_2", lat[1][2], 7);

    // Acks after done are ignored.
    @(posedge clk);
    #2;
    ack_v[0] = ~ack_v[0];
    ack_v[1] = ~ack_v[1];
    repeat (5) @(negedge clk);
    #2;
    chk("a_done_sticky", done_v[0], 1);
    chk("a_done_pkt_count", pc_v[0], 2);
    chk("a_done_no_flit", k[0], 8);
    snap = cur_log;

    // Async reset while done, then a run aborted during flit 2.
    enable  = 2'b00;
    resp_en = 1'b0;
    @(posedge clk);
    #2;
    reset    = 1'b1;
    ack_v[0] = 1'b0;
    ack_v[1] = 1'b0;
    #1;
    chk("async_reset_done", done_v[0], 0);
    chk("async_reset_data", data_v[0], 0);
    repeat (2) @(posedge clk);
    #2;
    reset   = 1'b0;
    resp_en = 1'b1;
    @(posedge clk);
    #1 enable[0] = 1'b1;
    wait_k(0, 3, 100, "a_reached_flit2");
    #1 reset = 1'b1;
    #1;
    chk("abort_req", req_v[0], 0);
    chk("abort_data", data_v[0], 0);
    chk("abort_pkt_count", pc_v[0], 0);
    resp_en   = 1'b0;
    ack_v[0]  = 1'b0;
    enable[0] = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset   = 1'b0;
    resp_en = 1'b1;
    @(posedge clk);
    #1 enable[0] = 1'b1;
    wait_done(0, 300, "a_restart_done");
    chk("a_restart_pkt_count", pc_v[0], 2);
    for (int j = 0; j < 8; j++) chk("restart_payload", cur_log[0][j], snap[0][j]);
    chk("a_head_spacing_gap0", lat[0][4], 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/traffic_source.md
Name: traffic_source

Overview:
- Parametrised successor to the single-stream packet generator.
- Emits PACKETS multi-flit packets over a 2-phase (toggle) req/ack channel.
- Configurable flit width, packet length, head/tail marking, a destination field in the head flit, an inter-packet gap, and pause control.
- Payload comes from a synthesizable LFSR, so a bench can predict every flit.
- Sits at a NoC router local input port as the traffic injector for simulation and on-chip self-test.

Parameters:
ID, 0, source identifier; XORed into LFSR seed.
SIZE, 16, flit width in bits; must be >= DEST_BITS+3.
FLITS, 4, flits per packet, 1..255.
PACKETS, 2, packets to send, 1..255; 0 = unlimited.
DEST_BITS, 4, width of destination field.
DEST_COUNT, 16, number of destinations, 1..2^DEST_BITS.
GAP, 0, idle cycles between last ack of a packet and next head, 0..255.
SEED, 1, LFSR seed; effective seed = (SEED ^ ID) and 32'hFFFFFFFF, forced to 1 if zero.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
enable  in  1  permits starting a new packet
ack  in  1  2-phase acknowledge; each toggle accepts one flit
req  out  1  2-phase request; each toggle presents a new flit
data  out  SIZE  current flit
done  out  1  high once PACKETS packets are fully acknowledged; never set when PACKETS=0
pkt_count  out  8  packets fully acknowledged; wraps 255->0 when PACKETS=0

Behaviour:
- Reset (async): req=0, data=0, done=0, pkt_count=0, flit index=0, gap counter=0, ack_old=0, LFSR=effective seed, state=IDLE.
- Ack detection: ack_rx = ack ^ ack_old. ack_old <= ack every cycle in every state, so a toggle seen outside WAIT is consumed and ignored.
- Flit format:
  - bit SIZE-1 = head.
  - bit SIZE-2 = tail.
  - Head flit: bits [SIZE-3 -: DEST_BITS] = dest; lower SIZE-2-DEST_BITS bits = LFSR[low].
  - Body and tail flits: bits [SIZE-3:0] = LFSR[low].
  - FLITS=1: the single flit has head=1 and tail=1.
- Destination: dest = pkt_count mod DEST_COUNT (round-robin), latched at head issue.
- LFSR: 32-bit Galois, taps 32,22,2,1 (mask 32'h80200003). Advances exactly once per flit issued. The issued flit uses the value before advance.
- States:
  - IDLE: if done=0 and enable=1, issue head flit (data<=flit, req<=~req, flit index<=1) and go WAIT. Latency is 1 clk from enable high to req toggle. If enable=0, stay.
  - WAIT: hold data and req stable. On ack_rx:
    - If flits remain, issue next flit on the same edge (req toggles, data updates) and stay in WAIT.
    - If this was the tail, pkt_count<=pkt_count+1 and flit index<=0, then:
      - if PACKETS!=0 and pkt_count+1==PACKETS, go DONE;
      - else if GAP>0, go GAP with counter=GAP;
      - else go IDLE.
  - GAP: decrement counter each cycle; at 1, go IDLE. enable is ignored during GAP.
  - DONE: done=1; terminal until reset; acks ignored.
- enable is sampled only in IDLE. Deasserting it mid-packet does not stall the packet; the packet always completes.
- Minimum spacing between flit issues is 1 cycle after ack_rx. Peak rate is one flit per ack round trip.
- Reset mid-packet: immediate abort, req returns to 0. The partner must be reset in the same window; this is required system-wide.
- Simulation-only: print "Packet Source <ID>" prefixed messages on head issue and tail ack via the shared debug task module, wrapped in a simulation-only guard.

Decomposition:
- Shared package/include (noc_defs): flit head/tail bit position macros, LFSR mask constant, state encodings (IDLE=0, WAIT=1, GAP=2, DONE=3).
- One sub-module: lfsr32 (clk, reset, advance, seed param, value out), reused by the sinks for payload checking.

Test Plan:
1. Defaults, enable=1, responder acks 2 cycles after each req toggle -> 8 req toggles; flit0 head=1 dest=0, flit3 tail=1, packet1 head dest=1; done=1 and pkt_count=2 after the 8th ack; payloads match a reference lfsr32.
2. FLITS=1, PACKETS=3 -> 3 flits, each with head=1 and tail=1; dest 0,1,2; done after the 3rd ack.
3. GAP=5 -> exactly 5 cycles in GAP plus 1 IDLE cycle between the tail ack edge and the next head's req toggle.
4. enable=0 after reset for 10 cycles -> req stays 0. Raise enable -> req toggles 1 clk later. Drop enable mid-packet -> the packet finishes, and no new head is issued until enable returns.
5. Spurious ack toggle in IDLE or GAP -> ignored; no flit skipped, no early advance.
6. reset asserted during flit 2 of packet 0 -> req=0, data=0, pkt_count=0 asynchronously. After release, packet 0 restarts with the identical payload of the first attempt.
